// File: rtl/line_scheduler.sv
// line_scheduler: paces GBA line pulls and cache reloads against the HDMI output raster
module line_scheduler #(
    parameter int GBA_LINES = 160,
    parameter int SCALE_NUM = 9,
    parameter int SCALE_DEN = 2,
    parameter int CACHE_DLY = 4
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       outFrameStart,
    input  logic       outLineEnd,
    input  logic       newFrameIn,
    input  logic       sameLine,
    output logic       pullLine,
    output logic       cacheUpdate,
    output logic [7:0] gbaLine,
    output logic       frameLocked,
    output logic [7:0] underrunCnt,
    output logic       errOverrun,
    output logic       errResync
);
    localparam int AW = $clog2(SCALE_NUM + SCALE_DEN) + 1;
    localparam int DW = $clog2(CACHE_DLY + 1);
    localparam logic [7:0] LAST_LINE = 8'(GBA_LINES - 1);

    typedef enum logic [1:0] {IDLE, WAIT_FRAME, ACTIVE, DONE} stateType;

    stateType state;
    logic [AW-1:0] acc, accSum;
    logic [DW-1:0] dly;
    logic busy, wrap, frameGo, lineEnd;

    // busy spans the pullLine cycle through the cacheUpdate cycle
    always_comb begin
        accSum = acc + AW'(SCALE_DEN);
        wrap = accSum >= AW'(SCALE_NUM);
        busy = dly != '0 || cacheUpdate;
        frameGo = outFrameStart && state != IDLE;
        lineEnd = outLineEnd && !outFrameStart && state == ACTIVE;
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state <= IDLE;
            acc <= '0;
            dly <= '0;
            pullLine <= 1'b0;
            cacheUpdate <= 1'b0;
            gbaLine <= '0;
            frameLocked <= 1'b0;
            underrunCnt <= '0;
            errOverrun <= 1'b0;
            errResync <= 1'b0;
        end else begin
            pullLine <= 1'b0;
            cacheUpdate <= dly == DW'(1);
            if (dly != '0)
                dly <= dly - DW'(1);
            if (pullLine && sameLine && underrunCnt != 8'hFF)
                underrunCnt <= underrunCnt + 8'd1;
            if (state == IDLE && newFrameIn)
                state <= WAIT_FRAME;
            if (frameGo) begin
                if (state == ACTIVE)
                    errResync <= 1'b1;
                state <= ACTIVE;
                acc <= '0;
                gbaLine <= '0;
                pullLine <= 1'b1;
                cacheUpdate <= 1'b0;
                dly <= DW'(CACHE_DLY);
                frameLocked <= 1'b1;
            end else if (lineEnd && busy) begin
                errOverrun <= 1'b1;
            end else if (lineEnd) begin
                acc <= wrap ? accSum - AW'(SCALE_NUM) : accSum;
                if (wrap && gbaLine == LAST_LINE) begin
                    state <= DONE;
                end else if (wrap) begin
                    gbaLine <= gbaLine + 8'd1;
                    pullLine <= 1'b1;
                    dly <= DW'(CACHE_DLY);
                end
            end
        end
    end
endmodule

// File: tb/tb_line_scheduler.sv
// tb_line_scheduler: scoreboard bench for line_scheduler
module tb_line_scheduler;
    localparam int DLY = 4;

    logic clk = 1'b0, rst = 1'b1;
    logic outFrameStart = 1'b0, outLineEnd = 1'b0, newFrameIn = 1'b1, sameLine = 1'b0;
    logic pullLine, cacheUpdate, frameLocked, errOverrun, errResync;
    logic [7:0] gbaLine, underrunCnt;

    int checks = 0, errors = 0, cyc = 0, pullSeen = 0, p0 = 0;
    int mState = 0, mLine = 0, mK = 0, mPull = -100, mAdv = 0;

    typedef struct {int cyc; int line;} pullExp;
    pullExp pullQ[$];
    int cacheQ[$];

    line_scheduler dut (
        .clk(clk), .rst(rst), .outFrameStart(outFrameStart), .outLineEnd(outLineEnd),
        .newFrameIn(newFrameIn), .sameLine(sameLine), .pullLine(pullLine),
        .cacheUpdate(cacheUpdate), .gbaLine(gbaLine), .frameLocked(frameLocked),
        .underrunCnt(underrunCnt), .errOverrun(errOverrun), .errResync(errResync)
    );

    always #5 clk = ~clk;

    initial forever begin
        @(posedge clk);
        cyc = cyc + 1;
    end

    task automatic check(input string tag, input int got, input int exp);
        checks++;
        if (got != exp) begin
            errors++;
            $display("FAIL %s got %0d expected %0d", tag, got, exp);
        end
    endtask

    task automatic expectPull(input int n);
        pullExp e;
        e.cyc = n + 1;
        e.line = mLine;
        pullQ.push_back(e);
        cacheQ.push_back(n + 1 + DLY);
        mPull = n + 1;
        mAdv++;
    endtask

    // drive one strobe cycle and advance the reference model
    task automatic pulse(input logic fs, input logic le);
        int n;
        @(negedge clk);
        outFrameStart = fs;
        outLineEnd = le;
        n = cyc;
        if (fs && mState != 0) begin
            if (cacheQ.size() > 0 && cacheQ[cacheQ.size() - 1] > n)
                void'(cacheQ.pop_back());
            mState = 2;
            mLine = 0;
            mK = 0;
            expectPull(n);
        end else if (le && mState == 2 && !(n >= mPull && n <= mPull + DLY)) begin
            mK++;
            if ((mK * 2) / 9 != ((mK - 1) * 2) / 9) begin
                if (mLine == 159) begin
                    mState = 3;
                end else begin
                    mLine++;
                    expectPull(n);
                end
            end
        end
        @(negedge clk);
        outFrameStart = 1'b0;
        outLineEnd = 1'b0;
    endtask

    task automatic advance(input int gap);
        int a;
        a = mAdv;
        for (int i = 0; i < 20 && mAdv == a; i++) begin
            repeat (gap) @(negedge clk);
            if (mState == 3)
                pulse(1'b1, 1'b0);
            else
                pulse(1'b0, 1'b1);
        end
    endtask

    initial forever begin
        @(negedge clk);
        if (pullLine)
            pullSeen++;
        if (pullQ.size() > 0 && pullQ[0].cyc == cyc) begin
            check("pull", int'(pullLine), 1);
            check("pullGbaLine", int'(gbaLine), pullQ[0].line);
            void'(pullQ.pop_front());
        end else if (pullLine) begin
            check("pullSpurious", int'(pullLine), 0);
        end
        if (cacheQ.size() > 0 && cacheQ[0] == cyc) begin
            check("cacheUpdate", int'(cacheUpdate), 1);
            void'(cacheQ.pop_front());
        end else if (cacheUpdate) begin
            check("cacheSpurious", int'(cacheUpdate), 0);
        end
    end

    initial begin
        repeat (2) @(negedge clk);
        check("rstPull", int'(pullLine), 0);
        check("rstCache", int'(cacheUpdate), 0);
        check("rstLine", int'(gbaLine), 0);
        check("rstLocked", int'(frameLocked), 0);
        check("rstUnder", int'(underrunCnt), 0);
        check("rstOverrun", int'(errOverrun), 0);
        check("rstResync", int'(errResync), 0);
        rst = 1'b0;
        repeat (3) @(negedge clk);
        mState = 1;
        check("waitLocked", int'(frameLocked), 0);
        pullSeen = 0;
        pulse(1'b1, 1'b0);
        repeat (6) @(negedge clk);
        check("lockLocked", int'(frameLocked), 1);
        check("lockLine", int'(gbaLine), 0);

        for (int k = 0; k < 720; k++) begin
            repeat (38) @(negedge clk);
            pulse(1'b0, 1'b1);
        end
        repeat (10) @(negedge clk);
        check("framePulls", pullSeen, 160);
        check("frameLast", int'(gbaLine), 159);
        pulse(1'b0, 1'b1);
        repeat (10) @(negedge clk);
        check("donePulls", pullSeen, 160);
        check("doneLocked", int'(frameLocked), 1);

        sameLine = 1'b1;
        for (int i = 0; i < 3; i++) advance(8);
        repeat (2) @(negedge clk);
        check("underrun3", int'(underrunCnt), 3);
        for (int i = 0; i < 300; i++) advance(8);
        repeat (2) @(negedge clk);
        check("underrunSat", int'(underrunCnt), 255);
        sameLine = 1'b0;

        check("overrunClear", int'(errOverrun), 0);
        advance(8);
        @(negedge clk);
        pulse(1'b0, 1'b1);
        repeat (8) @(negedge clk);
        check("overrun", int'(errOverrun), 1);
        check("overrunLine", int'(gbaLine), mLine);

        check("resyncClear", int'(errResync), 0);
        advance(8);
        for (int i = 0; i < 400 && !(mLine == 37 && mState == 2); i++) advance(8);
        check("resyncAt37", int'(gbaLine), 37);
        pulse(1'b1, 1'b0);
        repeat (2) @(negedge clk);
        check("resync", int'(errResync), 1);
        check("resyncLine", int'(gbaLine), 0);
        repeat (10) @(negedge clk);

        p0 = pullSeen;
        pulse(1'b1, 1'b1);
        @(negedge clk);
        rst = 1'b1;
        pullQ.delete();
        cacheQ.delete();
        mState = 0;
        mPull = -100;
        #1;
        check("midRstPull", int'(pullLine), 0);
        check("midRstCache", int'(cacheUpdate), 0);
        check("midRstLine", int'(gbaLine), 0);
        check("midRstLocked", int'(frameLocked), 0);
        check("midRstUnder", int'(underrunCnt), 0);
        check("midRstOverrun", int'(errOverrun), 0);
        check("midRstResync", int'(errResync), 0);
        newFrameIn = 1'b0;
        repeat (3) @(negedge clk);
        rst = 1'b0;
        check("simPulls", pullSeen - p0, 1);
        repeat (10) @(negedge clk);
        pulse(1'b1, 1'b0);
        repeat (10) @(negedge clk);
        check("idleLocked", int'(frameLocked), 0);
        check("idlePulls", pullSeen - p0, 1);
        check("pullQEmpty", pullQ.size(), 0);
        check("cacheQEmpty", cacheQ.size(), 0);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
